// File: rtl/rr_arb_mux.sv
// NCH-channel round-robin / forced-select arbiter with a registered valid/ready output stage.
// Optional packet locking (in_last/out_last ports) is enabled by defining RR_ARB_MUX_PKT_LOCK_EN.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  input  logic                 force_en,
  input  logic [SELW-1:0]      force_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  localparam int unsigned NCHU = NCH;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  logic             lock_q,      lock_d;
  logic [SELW-1:0]  lock_idx_q,  lock_idx_d;
  logic             out_last_q,  out_last_d;
`endif

  logic             load;
  logic             grant;
  logic             xfer;
  logic [SELW-1:0]  grant_idx;
  logic             rr_found;
  logic [SELW-1:0]  rr_idx;
  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] ch_data [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Search starts at ptr and wraps; the first valid channel wins.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NCHU; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NCHU) idx = idx - NCHU;
      if (!rr_found && in_valid[SELW'(idx)]) begin
        rr_found = 1'b1;
        rr_idx   = SELW'(idx);
      end
    end
  end

  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    if (force_en) begin
      if ((32'(force_sel) < NCHU) && in_valid[force_sel]) begin
        grant     = 1'b1;
        grant_idx = force_sel;
      end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    end else if (lock_q) begin
      grant     = in_valid[lock_idx_q];
      grant_idx = lock_idx_q;
`endif
    end else begin
      grant     = rr_found;
      grant_idx = rr_idx;
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign xfer     = rst_n && load && grant;
  assign ptr_next = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_sel_d   = grant_idx;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      out_last_d  = in_last[grant_idx];
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer && !force_en) begin
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      // Pointer only moves past a channel once its packet has ended.
      lock_d     = !in_last[grant_idx];
      lock_idx_d = grant_idx;
      if (in_last[grant_idx]) ptr_d = ptr_next;
`else
      ptr_d = ptr_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed, table-driven bench for rr_arb_mux (default build, NCH=4, WIDTH=32).
// Channel i always presents data 32'hA0+i.
module tb_rr_arb_mux;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*WIDTH-1:0] in_data;
  logic              force_en;
  logic [1:0]        force_sel;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        out_sel;

  int errors = 0;
  int checks = 0;

  rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic        ordy;
    logic        fen;
    logic [1:0]  fsel;
    logic [3:0]  e_ird;
    logic        e_ov;
    logic [1:0]  e_sel;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] iv, input logic ordy, input logic fen, input logic [1:0] fsel,
                     input logic [3:0] e_ird, input logic e_ov, input logic [1:0] e_sel,
                     input logic [31:0] e_data);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fen = fen; v.fsel = fsel;
    v.e_ird = e_ird; v.e_ov = e_ov; v.e_sel = e_sel; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = 32'hA0 + 32'(i);
    in_valid  = '0;
    out_ready = 1'b1;
    force_en  = 1'b0;
    force_sel = '0;
    rst_n     = 1'b0;

    // All four valid: plain rotation 0,1,2,3,0,1
    add(4'b1111, 1, 0, 0, 4'b0001, 1, 0, 32'hA0);
    add(4'b1111, 1, 0, 0, 4'b0010, 1, 1, 32'hA1);
    add(4'b1111, 1, 0, 0, 4'b0100, 1, 2, 32'hA2);
    add(4'b1111, 1, 0, 0, 4'b1000, 1, 3, 32'hA3);
    add(4'b1111, 1, 0, 0, 4'b0001, 1, 0, 32'hA0);
    add(4'b1111, 1, 0, 0, 4'b0010, 1, 1, 32'hA1);
    // ptr=2, channels 0 and 2 only: alternate 2,0,2,0
    add(4'b0101, 1, 0, 0, 4'b0100, 1, 2, 32'hA2);
    add(4'b0101, 1, 0, 0, 4'b0001, 1, 0, 32'hA0);
    add(4'b0101, 1, 0, 0, 4'b0100, 1, 2, 32'hA2);
    add(4'b0101, 1, 0, 0, 4'b0001, 1, 0, 32'hA0);
    // idle drains output, data/sel hold (ptr=1)
    add(4'b0000, 1, 0, 0, 4'b0000, 0, 0, 32'hA0);
    // ch1 beat then 3 stalled cycles, then ch2 (ptr=2)
    add(4'b0010, 1, 0, 0, 4'b0010, 1, 1, 32'hA1);
    add(4'b1111, 0, 0, 0, 4'b0000, 1, 1, 32'hA1);
    add(4'b1111, 0, 0, 0, 4'b0000, 1, 1, 32'hA1);
    add(4'b1111, 0, 0, 0, 4'b0000, 1, 1, 32'hA1);
    add(4'b1111, 1, 0, 0, 4'b0100, 1, 2, 32'hA2);
    add(4'b1111, 1, 0, 0, 4'b1000, 1, 3, 32'hA3);
    // ptr=0; forced grants must not move it
    add(4'b1111, 1, 1, 2, 4'b0100, 1, 2, 32'hA2);
    add(4'b1111, 1, 1, 2, 4'b0100, 1, 2, 32'hA2);
    add(4'b1111, 1, 1, 3, 4'b1000, 1, 3, 32'hA3);
    add(4'b1111, 1, 1, 3, 4'b1000, 1, 3, 32'hA3);
    add(4'b0111, 1, 1, 3, 4'b0000, 0, 3, 32'hA3);
    add(4'b1111, 0, 1, 1, 4'b0010, 1, 1, 32'hA1);
    add(4'b1111, 0, 1, 1, 4'b0000, 1, 1, 32'hA1);
    add(4'b1111, 1, 0, 0, 4'b0001, 1, 0, 32'hA0);
    add(4'b1000, 1, 0, 0, 4'b1000, 1, 3, 32'hA3);

    // Reset state
    #2;
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    in_valid = 4'b1111;
    #1;
    chk("reset_in_ready_valid", 32'(in_ready), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_out_sel", 32'(out_sel), 32'h0);
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      @(negedge clk);
      in_valid  = vecs[n].iv;
      out_ready = vecs[n].ordy;
      force_en  = vecs[n].fen;
      force_sel = vecs[n].fsel;
      #1;
      chk($sformatf("v%0d_in_ready", n), 32'(in_ready), 32'(vecs[n].e_ird));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", n), 32'(out_valid), 32'(vecs[n].e_ov));
      chk($sformatf("v%0d_out_sel", n), 32'(out_sel), 32'(vecs[n].e_sel));
      chk($sformatf("v%0d_out_data", n), out_data, vecs[n].e_data);
    end

    // Table ends with ptr=0 after ch3; make ptr nonzero and out_valid=1, then async reset
    @(negedge clk);
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    force_en  = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
    chk("pre_rst_out_sel", 32'(out_sel), 32'h3);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_ch1", 32'(out_sel), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_out_data", out_data, 32'h0);
    chk("async_rst_out_sel", 32'(out_sel), 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_out_sel", 32'(out_sel), 32'h0);
    chk("post_rst_out_data", out_data, 32'hA0);
    chk("post_rst_out_valid", 32'(out_valid), 32'h1);

    // Fairness: 8 consecutive transfers from ptr=1 hit each channel exactly twice
    begin
      int cnt[NCH];
      for (int i = 0; i < NCH; i++) cnt[i] = 0;
      for (int n = 0; n < 2*NCH; n++) begin
        @(posedge clk);
        #1;
        chk($sformatf("fair%0d_sel", n), 32'(out_sel), 32'((n + 1) % NCH));
        cnt[out_sel]++;
      end
      for (int i = 0; i < NCH; i++) chk($sformatf("fair_cnt_ch%0d", i), 32'(cnt[i]), 32'h2);
    end

    in_valid = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
